// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and typematic pulse generator.
// Each channel emits a one-cycle step pulse on press, then auto-repeats while held.
module button_conditioner #(
    parameter int unsigned NUM_BTN           = 6,
    parameter int unsigned DEBOUNCE_CYCLES   = 650000,
    parameter int unsigned HOLD_DELAY_CYCLES = 26000000,
    parameter int unsigned REPEAT_CYCLES     = 3250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] pulse_out,
    output logic [NUM_BTN-1:0] held_out
);

    localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX     = (HOLD_DELAY_CYCLES > REPEAT_CYCLES) ? HOLD_DELAY_CYCLES
                                                                           : REPEAT_CYCLES;
    localparam int unsigned TW       = $clog2(TMAX + 1);
    localparam int unsigned DB_TC    = DEBOUNCE_CYCLES - 1;
    localparam int unsigned HOLD_TC  = (HOLD_DELAY_CYCLES == 0) ? 0 : HOLD_DELAY_CYCLES - 1;
    localparam int unsigned REP_TC   = REPEAT_CYCLES - 1;
    localparam bit          REPEAT_EN = (HOLD_DELAY_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        logic          sync1;
        logic          sync2;
        logic          stable;
        logic          pulse_q;
        logic [CW-1:0] db_cnt;
        logic [TW-1:0] timer;
        state_t        state;

        // Sync, debounce and press/repeat sequencing for one button
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                stable  <= 1'b0;
                db_cnt  <= '0;
                timer   <= '0;
                pulse_q <= 1'b0;
                state   <= ST_IDLE;
            end else begin
                sync1 <= btn_in[g];
                sync2 <= sync1;

                if (sync2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == CW'(DB_TC)) begin
                    stable <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CW'(1);
                end

                pulse_q <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (stable) begin
                            pulse_q <= 1'b1;
                            timer   <= '0;
                            state   <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        // With repeat disabled, DELAY just parks until release
                        if (!stable) begin
                            state <= ST_IDLE;
                        end else if (REPEAT_EN) begin
                            if (timer == TW'(HOLD_TC)) begin
                                pulse_q <= 1'b1;
                                timer   <= '0;
                                state   <= ST_REPEAT;
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!stable) begin
                            state <= ST_IDLE;
                        end else if (timer == TW'(REP_TC)) begin
                            pulse_q <= 1'b1;
                            timer   <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign pulse_out[g] = pulse_q;
        assign held_out[g]  = stable;
    end

endmodule
